// File: rtl/seq_restoring_divider_if.sv
// Handshake and operand/result bundle for seq_restoring_divider.
// The master issues divide requests; the slave (the divider) returns results.
interface seq_restoring_divider_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic          chk_err;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, chk_err
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, chk_err
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
// Define DIV_SELFCHECK_EN to add a reconstruction check on each result; otherwise chk_err is tied low.
module seq_restoring_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   a_r;
  logic [VW:0]     p_r;
  logic [VW-1:0]   d_r;
  logic [DW-1:0]   q_out;
  logic [VW-1:0]   r_out;
  logic            dbz;
  logic            busy, done;
  logic            accept, last_step;
  logic [VW+DW:0]  step;

  // One restoring iteration on {P, A}: shift left, trial-subtract, keep or restore.
  function automatic logic [VW+DW:0] div_step(input logic [VW:0]   p,
                                              input logic [DW-1:0] a,
                                              input logic [VW-1:0] d);
    logic        [VW+1:0] sh;
    logic signed [VW+1:0] trial;
    sh    = {p, a[DW-1]};
    trial = $signed(sh) - $signed({2'b00, d});
    if (!trial[VW+1]) return {trial[VW:0], a[DW-2:0], 1'b1};
    else              return {sh[VW:0],    a[DW-2:0], 1'b0};
  endfunction

  assign accept    = bus.start && (state != RUN);
  assign last_step = (state == RUN) && (cnt == CW'(DW - 1));
  assign step      = div_step(p_r, a_r, d_r);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (bus.start) state_nxt = (bus.divisor == '0) ? DONE : RUN;
      end
      RUN:     if (cnt == CW'(DW - 1)) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Control and result registers; results change only on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      q_out <= '0;
      r_out <= '0;
      dbz   <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      dbz <= (bus.divisor == '0);
      if (bus.divisor == '0) begin
        q_out <= '1;
        r_out <= '0;
      end
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      if (last_step) begin
        q_out <= step[DW-1:0];
        r_out <= step[DW+VW-1:DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= bus.dividend;
      d_r <= bus.divisor;
      p_r <= '0;
    end else if (state == RUN) begin
      {p_r, a_r} <= step;
    end
  end

  assign bus.quotient    = q_out;
  assign bus.remainder   = r_out;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.div_by_zero = dbz;

`ifdef DIV_SELFCHECK_EN
  localparam int XW = DW + VW;
  logic [DW-1:0] dvd_r;
  logic [XW-1:0] recon;

  always_ff @(posedge clk) begin
    if (accept) dvd_r <= bus.dividend;
  end

  assign recon       = XW'(q_out) * XW'(d_r) + XW'(r_out);
  assign bus.chk_err = done && !dbz && ((recon != XW'(dvd_r)) || (r_out >= d_r));
`else
  assign bus.chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (DW=8, VW=4): handshake timing, corner cases,
// reset abort and an exhaustive golden sweep of all nonzero-divisor operand pairs.
module tb_seq_restoring_divider;
  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   k, nb, ndone;

  seq_restoring_divider_if #(.DW(8), .VW(4)) bus ();

  seq_restoring_divider #(.DW(8), .VW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle or in DONE; returns at the negedge of the done cycle.
  task automatic do_op(input logic [7:0] a, input logic [3:0] b, output int kk, output int nbusy);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start = 1'b0;
    kk    = 1;
    nbusy = 0;
    while (!bus.done && kk < 20) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      kk++;
    end
    chk("done_seen", 32'(bus.done), 32'd1);
  endtask

  task automatic chk_res(input string tag, input int q, input int r, input int z);
    chk({tag, "_q"},   32'(bus.quotient),    32'(q));
    chk({tag, "_r"},   32'(bus.remainder),   32'(r));
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(z));
    chk({tag, "_chk"}, 32'(bus.chk_err),     32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk_res("rst", 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 200 / 13 = 15 r 5, eight busy cycles, done in the ninth cycle
    do_op(8'd200, 4'd13, k, nb);
    chk("t1_lat", 32'(k), 32'd9);
    chk("t1_busy", 32'(nb), 32'd8);
    chk_res("t1", 15, 5, 0);
    @(negedge clk);
    chk("t1_pulse", 32'(bus.done), 32'd0);
    chk("t1_hold_q", 32'(bus.quotient), 32'd15);

    do_op(8'd255, 4'd15, k, nb);
    chk_res("t2a", 17, 0, 0);
    do_op(8'd7, 4'd9, k, nb);
    chk_res("t2b", 0, 7, 0);
    @(negedge clk);

    // divide by zero: done right after the accepting edge, no busy cycles
    do_op(8'd123, 4'd0, k, nb);
    chk("t3_lat", 32'(k), 32'd1);
    chk("t3_busy", 32'(nb), 32'd0);
    chk_res("t3", 255, 0, 1);
    @(negedge clk);
    chk("t3_hold_dbz", 32'(bus.div_by_zero), 32'd1);
    chk("t3_hold_done", 32'(bus.done), 32'd0);
    do_op(8'd100, 4'd10, k, nb);
    chk_res("t3b", 10, 0, 0);
    @(negedge clk);

    // start held high with scrambled operands during RUN
    bus.start    = 1'b1;
    bus.dividend = 8'd77;
    bus.divisor  = 4'd4;
    @(negedge clk);
    k = 1;
    while (!bus.done && k < 20) begin
      bus.dividend = 8'($urandom);
      bus.divisor  = 4'($urandom);
      @(negedge clk);
      k++;
    end
    chk("t4_lat", 32'(k), 32'd9);
    chk_res("t4a", 19, 1, 0);
    // back-to-back request issued in the DONE cycle
    bus.dividend = 8'd50;
    bus.divisor  = 4'd7;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t4_b2b_busy", 32'(bus.busy), 32'd1);
    chk("t4_hold_q", 32'(bus.quotient), 32'd19);
    chk("t4_hold_r", 32'(bus.remainder), 32'd1);
    k = 1;
    while (!bus.done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t4_b2b_lat", 32'(k), 32'd9);
    chk_res("t4b", 7, 1, 0);

    // reset asserted in the fourth RUN cycle of 9 / 3 aborts the operation
    bus.start    = 1'b1;
    bus.dividend = 8'd9;
    bus.divisor  = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_run", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_done", 32'(bus.done), 32'd0);
    chk_res("t5rst", 0, 0, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("t5_no_done", 32'(ndone), 32'd0);
    do_op(8'd9, 4'd3, k, nb);
    chk_res("t5b", 3, 0, 0);

    // golden sweep of every dividend with every nonzero divisor
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_op(8'(a), 4'(b), k, nb);
        chk_res("sweep", a / b, a % b, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
